// File: rtl/arith_pkg.sv
// -----------------------------------------------------------------------------
// arith_pkg
// Shared definitions for arith_seq_unit and its datapath:
//   - ALU_FUN operation codes (FUN_ADD, FUN_SUB, FUN_MUL, FUN_DIV)
//   - controller state encoding (state_t)
// No ports.
// -----------------------------------------------------------------------------
package arith_pkg;

    localparam logic [1:0] FUN_ADD = 2'b00;
    localparam logic [1:0] FUN_SUB = 2'b01;
    localparam logic [1:0] FUN_MUL = 2'b10;
    localparam logic [1:0] FUN_DIV = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/seq_mul_div.sv
// -----------------------------------------------------------------------------
// seq_mul_div
// Iterative datapath shared by multiply (shift-add) and restoring divide.
// One bit of work per step; WIDTH steps per operation.
//
// The working register pair {acc_hi, acc_lo} is used by both operations:
//   mul: acc_lo starts as the multiplier A; each step conditionally adds B to
//        acc_hi and shifts the pair right. Final pair = 2*WIDTH product.
//   div: acc_lo starts as the dividend A; each step shifts the pair left and
//        subtracts B from acc_hi when it fits, shifting a quotient bit into
//        acc_lo. Final pair = {remainder, quotient}.
//
// Ports:
//   CLK, RST_n  clock, async active-low reset
//   load        capture a_in, clear accumulator, preset counter
//   step        perform one iteration (ignored while load is high)
//   op_div      1 = divide, 0 = multiply
//   a_in        operand A, sampled on load
//   b_op        operand B (held stable by the caller for the whole operation)
//   res_next    value the pair takes after the current step
//   last        counter has reached zero: the current step is the final one
// -----------------------------------------------------------------------------
module seq_mul_div #(
    parameter int WIDTH = 8
) (
    input  logic                 CLK,
    input  logic                 RST_n,
    input  logic                 load,
    input  logic                 step,
    input  logic                 op_div,
    input  logic [WIDTH-1:0]     a_in,
    input  logic [WIDTH-1:0]     b_op,
    output logic [2*WIDTH-1:0]   res_next,
    output logic                 last
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] rem_diff;
    logic             rem_ge;

    always_comb begin
        mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, b_op} : {(WIDTH+1){1'b0}});
        rem_sh   = {acc_hi, acc_lo[WIDTH-1]};
        rem_ge   = (rem_sh >= {1'b0, b_op});
        // When rem_sh >= b_op the true difference is below b_op, so WIDTH
        // bits are enough to hold it.
        rem_diff = rem_sh[WIDTH-1:0] - b_op;
        if (op_div) begin
            if (rem_ge)
                res_next = {rem_diff, acc_lo[WIDTH-2:0], 1'b1};
            else
                res_next = {rem_sh[WIDTH-1:0], acc_lo[WIDTH-2:0], 1'b0};
        end else begin
            res_next = {mul_sum, acc_lo[WIDTH-1:1]};
        end
        last = (cnt == '0);
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            acc_hi <= '0;
            acc_lo <= '0;
            cnt    <= '0;
        end else if (load) begin
            acc_hi <= '0;
            acc_lo <= a_in;
            cnt    <= CNT_W'(WIDTH - 1);
        end else if (step) begin
            {acc_hi, acc_lo} <= res_next;
            // Saturate at zero; the controller leaves CALC on the zero step.
            if (cnt != '0)
                cnt <= cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/arith_seq_unit.sv
// -----------------------------------------------------------------------------
// arith_seq_unit
// Sequential arithmetic unit: single-cycle add/sub, WIDTH-cycle multiply and
// restoring divide. One request at a time; Busy covers the whole operation.
//
// Ports:
//   CLK           clock, rising edge
//   RST_n         async active-low reset
//   A, B          unsigned operands (latched on accept)
//   ALU_FUN       00 add, 01 sub, 10 mul, 11 div (latched on accept)
//   Arith_Enable  start request, honoured only in IDLE
//   Arith_OUT     result register (2*WIDTH)
//   Arith_Valid   one-cycle pulse in DONE
//   Busy          high from the cycle after accept through DONE
//   Carry_Flag    add carry-out / sub borrow, 0 for mul/div
//   Div_Zero      divide by zero occurred on the last operation
// -----------------------------------------------------------------------------
module arith_seq_unit
    import arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 CLK,
    input  logic                 RST_n,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic [1:0]           ALU_FUN,
    input  logic                 Arith_Enable,
    output logic [2*WIDTH-1:0]   Arith_OUT,
    output logic                 Arith_Valid,
    output logic                 Busy,
    output logic                 Carry_Flag,
    output logic                 Div_Zero
);

    state_t state, state_nxt;

    logic [WIDTH-1:0]   b_lat;
    logic [1:0]         fun_lat;

    logic               accept;
    logic               calc_step;
    logic               calc_last;
    logic               dp_last;
    logic [2*WIDTH-1:0] dp_res;

    logic [WIDTH:0]     add_res;
    logic [WIDTH:0]     sub_res;

    // ---------------- state register ----------------
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (Arith_Enable) begin
                    unique case (ALU_FUN)
                        FUN_ADD, FUN_SUB: state_nxt = ST_DONE;
                        FUN_MUL:          state_nxt = ST_CALC;
                        FUN_DIV:          state_nxt = (B == '0) ? ST_DONE : ST_CALC;
                    endcase
                end
            end
            ST_CALC: if (dp_last) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- output / control decode ----------------
    always_comb begin
        Busy        = (state != ST_IDLE);
        Arith_Valid = (state == ST_DONE);
        accept      = (state == ST_IDLE) && Arith_Enable;
        calc_step   = (state == ST_CALC);
        calc_last   = (state == ST_CALC) && dp_last;
    end

    seq_mul_div #(.WIDTH(WIDTH)) u_seq_mul_div (
        .CLK      (CLK),
        .RST_n    (RST_n),
        .load     (accept),
        .step     (calc_step),
        .op_div   (fun_lat == FUN_DIV),
        .a_in     (A),
        .b_op     (b_lat),
        .res_next (dp_res),
        .last     (dp_last)
    );

    always_comb begin
        add_res = {1'b0, A} + {1'b0, B};
        sub_res = {1'b0, A} - {1'b0, B};
    end

    // Result registers. Single-cycle operations are resolved on the accept
    // edge (inputs equal the latched values at that instant) so the result is
    // already registered when DONE is entered; iterative ones are captured on
    // the final CALC edge. Nothing changes outside those two edges.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            b_lat      <= '0;
            fun_lat    <= FUN_ADD;
            Arith_OUT  <= '0;
            Carry_Flag <= 1'b0;
            Div_Zero   <= 1'b0;
        end else if (accept) begin
            b_lat   <= B;
            fun_lat <= ALU_FUN;
            unique case (ALU_FUN)
                FUN_ADD: begin
                    Arith_OUT  <= {{WIDTH{1'b0}}, add_res[WIDTH-1:0]};
                    Carry_Flag <= add_res[WIDTH];
                    Div_Zero   <= 1'b0;
                end
                FUN_SUB: begin
                    Arith_OUT  <= {{WIDTH{1'b0}}, sub_res[WIDTH-1:0]};
                    Carry_Flag <= sub_res[WIDTH];
                    Div_Zero   <= 1'b0;
                end
                FUN_DIV: begin
                    if (B == '0) begin
                        Arith_OUT  <= {A, {WIDTH{1'b1}}};
                        Carry_Flag <= 1'b0;
                        Div_Zero   <= 1'b1;
                    end
                end
                FUN_MUL: ;
            endcase
        end else if (calc_last) begin
            Arith_OUT  <= dp_res;
            Carry_Flag <= 1'b0;
            Div_Zero   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_arith_seq_unit.sv
// -----------------------------------------------------------------------------
// tb_arith_seq_unit
// Directed table of operations with hand-computed results and latencies,
// followed by hand-written sequences for ignored requests, held enable and
// mid-operation reset.
// -----------------------------------------------------------------------------
module tb_arith_seq_unit;
    import arith_pkg::*;

    localparam int W = 8;

    logic           CLK;
    logic           RST_n;
    logic [W-1:0]   A;
    logic [W-1:0]   B;
    logic [1:0]     ALU_FUN;
    logic           Arith_Enable;
    logic [2*W-1:0] Arith_OUT;
    logic           Arith_Valid;
    logic           Busy;
    logic           Carry_Flag;
    logic           Div_Zero;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [1:0]     fun;
        logic [2*W-1:0] out;
        logic           c;
        logic           dz;
        int             lat;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    arith_seq_unit #(.WIDTH(W)) dut (
        .CLK          (CLK),
        .RST_n        (RST_n),
        .A            (A),
        .B            (B),
        .ALU_FUN      (ALU_FUN),
        .Arith_Enable (Arith_Enable),
        .Arith_OUT    (Arith_OUT),
        .Arith_Valid  (Arith_Valid),
        .Busy         (Busy),
        .Carry_Flag   (Carry_Flag),
        .Div_Zero     (Div_Zero)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
        end
    endtask

    // Issue one request and follow it to completion.
    task automatic run_op(input vec_t v, input int idx);
        int       lat;
        logic     busy_ok;
        logic [2*W-1:0] out_v;
        logic     c_v, dz_v;
        string    tag;
        tag = $sformatf("v%0d", idx);
        @(negedge CLK);
        A = v.a; B = v.b; ALU_FUN = v.fun; Arith_Enable = 1'b1;
        @(negedge CLK);
        // Scramble inputs: the operation must keep using the latched values.
        Arith_Enable = 1'b0;
        A = W'($urandom); B = W'($urandom); ALU_FUN = 2'($urandom);
        lat = 0; busy_ok = 1'b1;
        out_v = '0; c_v = 1'b0; dz_v = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            if (!Busy) busy_ok = 1'b0;
            if (Arith_Valid) begin
                lat = k; out_v = Arith_OUT; c_v = Carry_Flag; dz_v = Div_Zero;
                break;
            end
            @(negedge CLK);
        end
        check({tag, "_latency"}, lat, v.lat);
        check({tag, "_out"}, 32'(out_v), 32'(v.out));
        check({tag, "_carry"}, 32'(c_v), 32'(v.c));
        check({tag, "_divzero"}, 32'(dz_v), 32'(v.dz));
        check({tag, "_busy_during"}, 32'(busy_ok), 32'd1);
        @(negedge CLK);
        check({tag, "_after_valid_busy"}, {30'd0, Arith_Valid, Busy}, 32'd0);
        check({tag, "_hold_out"}, 32'(Arith_OUT), 32'(v.out));
    endtask

    initial begin
        int       nvalid;
        int       first_k;
        logic [2*W-1:0] first_out;
        logic [3:0] pat;
        logic     busy2;

        //            a    b    fun      out       c     dz    lat
        vecs[0]  = '{8'd200, 8'd100, FUN_ADD, 16'h002C, 1'b1, 1'b0, 1};
        vecs[1]  = '{8'd5,   8'd7,   FUN_SUB, 16'h00FE, 1'b1, 1'b0, 1};
        vecs[2]  = '{8'd255, 8'd255, FUN_MUL, 16'hFE01, 1'b0, 1'b0, 9};
        vecs[3]  = '{8'd100, 8'd7,   FUN_DIV, 16'h020E, 1'b0, 1'b0, 9};
        vecs[4]  = '{8'd9,   8'd0,   FUN_DIV, 16'h09FF, 1'b0, 1'b1, 1};
        vecs[5]  = '{8'd1,   8'd2,   FUN_ADD, 16'h0003, 1'b0, 1'b0, 1};
        vecs[6]  = '{8'd255, 8'd1,   FUN_ADD, 16'h0000, 1'b1, 1'b0, 1};
        vecs[7]  = '{8'd7,   8'd5,   FUN_SUB, 16'h0002, 1'b0, 1'b0, 1};
        vecs[8]  = '{8'd0,   8'd0,   FUN_SUB, 16'h0000, 1'b0, 1'b0, 1};
        vecs[9]  = '{8'd0,   8'd200, FUN_MUL, 16'h0000, 1'b0, 1'b0, 9};
        vecs[10] = '{8'd13,  8'd11,  FUN_MUL, 16'h008F, 1'b0, 1'b0, 9};
        vecs[11] = '{8'd255, 8'd1,   FUN_DIV, 16'h00FF, 1'b0, 1'b0, 9};
        vecs[12] = '{8'd3,   8'd10,  FUN_DIV, 16'h0300, 1'b0, 1'b0, 9};
        vecs[13] = '{8'd200, 8'd200, FUN_DIV, 16'h0001, 1'b0, 1'b0, 9};
        vecs[14] = '{8'd0,   8'd0,   FUN_DIV, 16'h00FF, 1'b0, 1'b1, 1};
        vecs[15] = '{8'd1,   8'd128, FUN_MUL, 16'h0080, 1'b0, 1'b0, 9};
        vecs[16] = '{8'd100, 8'd155, FUN_SUB, 16'h00C9, 1'b1, 1'b0, 1};

        RST_n = 1'b0; A = '0; B = '0; ALU_FUN = FUN_ADD; Arith_Enable = 1'b0;
        repeat (3) @(negedge CLK);
        check("reset_state", {11'd0, Arith_OUT, Arith_Valid, Busy, Carry_Flag, Div_Zero, 1'b0}, 32'd0);
        RST_n = 1'b1;

        for (int i = 0; i < NV; i++) run_op(vecs[i], i);

        // Requests and operand changes while busy are ignored.
        @(negedge CLK);
        A = 8'd3; B = 8'd4; ALU_FUN = FUN_MUL; Arith_Enable = 1'b1;
        nvalid = 0; first_k = 0; first_out = '0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge CLK);
            if (Arith_Valid) begin
                nvalid++;
                if (first_k == 0) begin first_k = k; first_out = Arith_OUT; end
            end
            if (k == 1) Arith_Enable = 1'b0;
            if (k == 3) begin A = 8'd200; B = 8'd50; ALU_FUN = FUN_ADD; Arith_Enable = 1'b1; end
            if (k == 4) Arith_Enable = 1'b0;
        end
        check("busy_ignore_nvalid", nvalid, 1);
        check("busy_ignore_latency", first_k, 9);
        check("busy_ignore_out", 32'(first_out), 32'h000C);

        // Enable held high: DONE ignores it, next IDLE cycle accepts again.
        @(negedge CLK);
        A = 8'd1; B = 8'd1; ALU_FUN = FUN_ADD; Arith_Enable = 1'b1;
        pat = '0; busy2 = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge CLK);
            pat[4-k] = Arith_Valid;
            if (k == 2) busy2 = Busy;
            if (k == 4) Arith_Enable = 1'b0;
        end
        check("held_enable_valid_pattern", 32'(pat), 32'b1010);
        check("held_enable_idle_gap_busy", 32'(busy2), 32'd0);
        check("held_enable_out", 32'(Arith_OUT), 32'h0002);

        // Reset in the middle of a divide.
        @(negedge CLK);
        A = 8'd100; B = 8'd7; ALU_FUN = FUN_DIV; Arith_Enable = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge CLK);
            if (k == 1) Arith_Enable = 1'b0;
        end
        check("pre_reset_busy", 32'(Busy), 32'd1);
        RST_n = 1'b0;
        #1;
        check("async_reset_outputs", {11'd0, Arith_OUT, Arith_Valid, Busy, Carry_Flag, Div_Zero, 1'b0}, 32'd0);
        @(negedge CLK);
        RST_n = 1'b1;
        nvalid = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge CLK);
            if (Arith_Valid || Busy) nvalid++;
        end
        check("no_valid_after_reset", nvalid, 0);

        // Unit is usable again after the abandoned request.
        run_op(vecs[3], 100);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/arith_seq_unit.md
ARITH_SEQ_UNIT -- requirements
Module: arith_seq_unit

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits (legal 4..32).
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 RST_n  input  1  reset, asynchronous, active-low.
REQ-004 A  input  WIDTH  operand A, unsigned.
REQ-005 B  input  WIDTH  operand B, unsigned.
REQ-006 ALU_FUN  input  2  operation: 00 add, 01 sub, 10 mul, 11 div.
REQ-007 Arith_Enable  input  1  start request, sampled only when Busy=0.
REQ-008 Arith_OUT  output  2*WIDTH  result register.
REQ-009 Arith_Valid  output  1  one-cycle pulse, Arith_OUT and flags valid.
REQ-010 Busy  output  1  high while an operation is in progress.
REQ-011 Carry_Flag  output  1  add carry-out / sub borrow.
REQ-012 Div_Zero  output  1  divide-by-zero indicator.

Function
REQ-013 States IDLE, CALC, DONE; IDLE after reset.
REQ-014 IDLE + Arith_Enable=1: latch A, B, ALU_FUN into internal registers; Busy=1 from next cycle.
REQ-015 Add/sub: IDLE -> DONE; Arith_Valid asserted exactly 1 cycle after accepting edge; Busy=1 during that cycle.
REQ-016 Add: Arith_OUT = zero-extended {carry, A+B} low WIDTH bits in [WIDTH-1:0], Carry_Flag = carry-out, upper bits zero.
REQ-017 Sub: Arith_OUT[WIDTH-1:0] = (A-B) mod 2^WIDTH, Carry_Flag = 1 when A<B, upper bits zero.
REQ-018 Mul: shift-add, one partial product per cycle; IDLE -> CALC for WIDTH cycles -> DONE; Arith_Valid WIDTH+1 cycles after accept; Arith_OUT = full 2*WIDTH product; Carry_Flag=0.
REQ-019 Div: restoring, one quotient bit per cycle; same latency as mul; Arith_OUT[WIDTH-1:0]=quotient, Arith_OUT[2*WIDTH-1:WIDTH]=remainder; Carry_Flag=0.
REQ-020 Div with latched B=0: skip CALC, go to DONE (latency 1); quotient all ones, remainder = A, Div_Zero=1.
REQ-021 Div_Zero=0 for every other completed operation; flags and Arith_OUT update only in the DONE cycle and hold until next DONE.
REQ-022 DONE -> IDLE unconditionally; Arith_Enable in DONE cycle ignored (no back-to-back accept); Busy=0 in the cycle after DONE.
REQ-023 Arith_Enable and operand/ALU_FUN changes while Busy=1 ignored; operation uses latched values.
REQ-024 Iteration counter width clog2(WIDTH+1); counts WIDTH-1 down to 0, no wrap beyond.
REQ-025 Arith_Valid never asserted outside DONE; exactly one pulse per accepted request.

Reset
REQ-026 RST_n=0 immediately forces: state IDLE, Arith_OUT=0, Arith_Valid=0, Busy=0, Carry_Flag=0, Div_Zero=0, counter and latched operands 0.
REQ-027 Reset mid-operation abandons it; no Arith_Valid pulse for that request after release.
REQ-028 First accept possible on first rising edge with RST_n=1 and Arith_Enable=1.

Structure
REQ-029 Shared package arith_pkg: ALU_FUN codes (FUN_ADD, FUN_SUB, FUN_MUL, FUN_DIV) and state enum.
REQ-030 Sub-module seq_mul_div holds the iterative shift-add / restoring-divide datapath (accumulator, shift register, counter); top holds FSM, add/sub, output registers.
REQ-031 No combinational path from inputs to outputs.

Verification (WIDTH=8)
REQ-032 Add A=200 B=100 -> 1 cycle later Arith_Valid, Arith_OUT=0x002C, Carry_Flag=1, Div_Zero=0.
REQ-033 Sub A=5 B=7 -> 1 cycle later Arith_OUT=0x00FE, Carry_Flag=1.
REQ-034 Mul A=255 B=255 -> Arith_Valid 9 cycles after accept, Arith_OUT=0xFE01, Busy high cycles 1..9.
REQ-035 Div A=100 B=7 -> 9 cycles later Arith_OUT=0x020E (rem 2, quot 14); Div A=9 B=0 -> 1 cycle later Arith_OUT=0x09FF, Div_Zero=1.
REQ-036 Start mul A=3 B=4, change A/B/ALU_FUN and pulse Arith_Enable at cycle 3 -> single Valid, Arith_OUT=0x000C.
REQ-037 Start div, assert RST_n=0 at cycle 4 -> all outputs 0 immediately, no Valid pulse in 20 cycles after release without new request.
